// File: rtl/serial_framer.sv
// Parallel-to-serial framer: start pulse, WIDTH data bits MSB first, finish pulse,
// then GAP idle cycles. A one-word holding register allows back-to-back frames.
module serial_framer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             start,
  output logic             ser,
  output logic             finish,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_FINISH,
    S_GAP
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    bitcnt_q;
  logic [3:0]       gapcnt_q;
  logic             start_q;
  logic             ser_q;
  logic             finish_q;

  logic accept;
  logic frame_done;

  assign din_ready = !hold_full_q && !rst;
  assign accept    = din_valid && din_ready;

  // Edges on which the FSM would return to IDLE; a waiting word is loaded there
  // instead, so refilled frames run at WIDTH+2+GAP cycles per word.
  assign frame_done = (state_q == S_IDLE) ||
                      (state_q == S_FINISH && GAP == 0) ||
                      (state_q == S_GAP && gapcnt_q == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      gapcnt_q    <= 4'd0;
      start_q     <= 1'b0;
      ser_q       <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge register values and later defaults are safely overridden.
      start_q  <= 1'b0;
      ser_q    <= 1'b0;
      finish_q <= 1'b0;

      if (accept) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end

      if (frame_done) begin
        if (hold_full_q) begin
          shreg_q     <= hold_q;
          hold_full_q <= 1'b0;
          start_q     <= 1'b1;
          state_q     <= S_START;
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_START: begin
            // Outputs are registered, so the MSB is presented on the edge leaving START.
            ser_q    <= shreg_q[WIDTH-1];
            shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_q <= BIT_LAST;
            state_q  <= S_DATA;
          end
          S_DATA: begin
            if (bitcnt_q == '0) begin
              finish_q <= 1'b1;
              state_q  <= S_FINISH;
            end else begin
              ser_q    <= shreg_q[WIDTH-1];
              shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
              bitcnt_q <= bitcnt_q - CW'(1);
            end
          end
          S_FINISH: begin
            gapcnt_q <= GAP_LOAD;
            state_q  <= S_GAP;
          end
          S_GAP: begin
            gapcnt_q <= gapcnt_q - 4'd1;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign start  = start_q;
  assign ser    = ser_q;
  assign finish = finish_q;
  assign busy   = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_serial_framer.sv
// Scoreboard bench for serial_framer: default instance (8/1) and a WIDTH=4, GAP=0 instance.
module tb_serial_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din_a;
  logic       vld_a;
  logic       rdy_a, start_a, ser_a, fin_a, busy_a;
  logic [3:0] din_b;
  logic       vld_b;
  logic       rdy_b, start_b, ser_b, fin_b, busy_b;

  serial_framer #(.WIDTH(8), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .start(start_a), .ser(ser_a), .finish(fin_a), .busy(busy_a)
  );

  serial_framer #(.WIDTH(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .start(start_b), .ser(ser_b), .finish(fin_b), .busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Scoreboard queues: words pushed by stimulus, start cycles pushed by monitors.
  logic [7:0] exp_qa[$];
  logic [3:0] exp_qb[$];
  int         start_qa[$];
  int         start_qb[$];
  bit         act_a = 0, act_b = 0;
  int         fin_cnt_a = 0;
  logic [7:0] last_a;

  initial begin : mon_a
    int bits; logic [7:0] sh; bit bad;
    bits = 0; sh = '0; bad = 0;
    forever begin
      @(negedge clk);
      if (fin_a) fin_cnt_a++;
      if (rst) begin
        act_a = 0;
      end else if (act_a) begin
        if (bits < 8) begin
          if (start_a || fin_a) bad = 1;
          sh = {sh[6:0], ser_a};
          bits++;
        end else begin
          check("a_data_clean", bad, 0);
          check("a_finish", {start_a, fin_a, ser_a}, 3'b010);
          last_a = sh;
          if (exp_qa.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected_frame: got %0h required none", sh);
          end else begin
            check("a_word", sh, exp_qa.pop_front());
          end
          act_a = 0;
        end
      end else if (start_a) begin
        check("a_start_ser", {ser_a, fin_a}, 0);
        start_qa.push_back(cyc);
        act_a = 1; bits = 0; bad = 0;
      end else if (fin_a) begin
        check("a_stray_finish", fin_a, 0);
      end
    end
  end

  initial begin : mon_b
    int bits; logic [3:0] sh; bit bad;
    bits = 0; sh = '0; bad = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act_b = 0;
      end else if (act_b) begin
        if (bits < 4) begin
          if (start_b || fin_b) bad = 1;
          sh = {sh[2:0], ser_b};
          bits++;
        end else begin
          check("b_data_clean", bad, 0);
          check("b_finish", {start_b, fin_b, ser_b}, 3'b010);
          if (exp_qb.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected_frame: got %0h required none", sh);
          end else begin
            check("b_word", sh, exp_qb.pop_front());
          end
          act_b = 0;
        end
      end else if (start_b) begin
        check("b_start_ser", {ser_b, fin_b}, 0);
        start_qb.push_back(cyc);
        act_b = 1; bits = 0; bad = 0;
      end else if (fin_b) begin
        check("b_stray_finish", fin_b, 0);
      end
    end
  end

  // Holds valid; drives garbage on din while not ready. Returns the accept edge number.
  task automatic send_a(input logic [7:0] w, output int acc);
    int budget = 100;
    @(negedge clk);
    vld_a = 1'b1;
    while (!rdy_a && budget > 0) begin
      din_a = ~w;
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check("a_accept_timeout", rdy_a, 1);
      acc = -1;
      return;
    end
    din_a = w;
    exp_qa.push_back(w);
    @(posedge clk);
    #1 acc = cyc;
  endtask

  task automatic send_b(input logic [3:0] w, output int acc);
    int budget = 100;
    @(negedge clk);
    vld_b = 1'b1;
    while (!rdy_b && budget > 0) begin
      din_b = ~w;
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check("b_accept_timeout", rdy_b, 1);
      acc = -1;
      return;
    end
    din_b = w;
    exp_qb.push_back(w);
    @(posedge clk);
    #1 acc = cyc;
  endtask

  task automatic drain_a();
    int budget = 300;
    while ((exp_qa.size() != 0 || act_a) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("a_drain_timeout", exp_qa.size(), 0);
  endtask

  task automatic drain_b();
    int budget = 300;
    while ((exp_qb.size() != 0 || act_b) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("b_drain_timeout", exp_qb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, acc1, acc2, fc, rcnt, bcnt;
    rst = 1'b1; vld_a = 1'b0; din_a = '0; vld_b = 1'b0; din_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_outputs", {start_a, ser_a, fin_a, busy_a, rdy_a}, 0);
    check("rst_b_outputs", {start_b, ser_b, fin_b, busy_b, rdy_b}, 0);
    rst = 1'b0;
    #1;
    check("rst_a_ready_after", rdy_a, 1);
    check("rst_b_ready_after", rdy_b, 1);

    // 1: single word 8'hE7
    start_qa.delete();
    send_a(8'hE7, acc);
    vld_a = 1'b0;
    repeat (12) @(negedge clk);
    check("t1_gap_busy", {busy_a, start_a, ser_a, fin_a}, 4'b1000);
    @(negedge clk);
    check("t1_idle_busy", busy_a, 0);
    drain_a();
    check("t1_latency", (start_qa.size() > 0) ? start_qa[0] - acc : -1, 1);
    check("t1_mod3", last_a % 3, 0);

    // 2: back-to-back 8'hA5, 8'h3C
    start_qa.delete();
    send_a(8'hA5, acc1);
    send_a(8'h3C, acc2);
    vld_a = 1'b0;
    check("t2_second_accept", acc2 - acc1, 2);
    rcnt = 0; bcnt = 0;
    for (int c = acc2; c <= acc1 + 22; c++) begin
      @(negedge clk);
      if (c <= acc1 + 11 && rdy_a) rcnt++;
      if (c == acc1 + 12) check("t2_ready_after_load", rdy_a, 1);
      if (!busy_a) bcnt++;
    end
    check("t2_ready_low_cycles", rcnt, 0);
    check("t2_busy_drop_cycles", bcnt, 0);
    drain_a();
    check("t2_frames", start_qa.size(), 2);
    if (start_qa.size() >= 2) check("t2_period", start_qa[1] - start_qa[0], 11);

    // 3: backpressure, valid held while hold register full
    start_qa.delete();
    send_a(8'h01, acc);
    send_a(8'h80, acc);
    send_a(8'hFF, acc);
    vld_a = 1'b0;
    drain_a();
    check("t3_frames", start_qa.size(), 3);
    if (start_qa.size() >= 3) check("t3_period", start_qa[2] - start_qa[1], 11);

    // 4: reset mid-frame of 8'h5A, then clean frame of 8'h0F
    fc = fin_cnt_a;
    send_a(8'h5A, acc);
    vld_a = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_bit3", ser_a, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_async_outputs", {start_a, ser_a, fin_a, busy_a, rdy_a}, 0);
    repeat (2) @(negedge clk);
    exp_qa.delete();
    rst = 1'b0;
    #1;
    check("t4_ready_after_release", rdy_a, 1);
    repeat (12) @(negedge clk);
    check("t4_no_finish", fin_cnt_a - fc, 0);
    start_qa.delete();
    send_a(8'h0F, acc);
    vld_a = 1'b0;
    drain_a();
    check("t4_clean_frame", start_qa.size(), 1);

    // 5: WIDTH=4, GAP=0 instance
    start_qb.delete();
    send_b(4'h9, acc);
    send_b(4'h6, acc);
    vld_b = 1'b0;
    drain_b();
    check("t5_frames", start_qb.size(), 2);
    if (start_qb.size() >= 2) check("t5_period", start_qb[1] - start_qb[0], 6);

    // 6: boundary data
    start_qa.delete();
    send_a(8'h00, acc);
    send_a(8'hFF, acc);
    vld_a = 1'b0;
    drain_a();
    check("t6_frames", start_qa.size(), 2);
    if (start_qa.size() >= 2) check("t6_period", start_qa[1] - start_qa[0], 11);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_framer.md
# serial_framer

Parallel-to-serial framer that feeds the serial mod3 unit. Accepts WIDTH-bit words over a valid/ready handshake and emits each word as a framed bit stream:
- a one-cycle `start` pulse;
- WIDTH data bits, MSB first, on `ser`;
- a one-cycle `finish` pulse with `ser=0`;
- GAP idle cycles.

A one-word holding register lets the next word be accepted while the current frame is transmitting, so frames can run back-to-back.

## Interface
- WIDTH, 8, data word width; legal range 2..32.
- GAP, 1, idle cycles after `finish` before the next `start`; legal range 0..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  WIDTH  word to transmit; sampled only on accept.
- din_valid  in  1  `din` is valid.
- din_ready  out  1  holding register empty; forced to 0 while `rst` is high.
- start  out  1  frame-start pulse, one cycle.
- ser  out  1  serial data bit, MSB first.
- finish  out  1  frame-end pulse, one cycle.
- busy  out  1  FSM not in IDLE, or holding register full.

## Operation
- Accept: on an edge with `din_valid && din_ready`, `hold <= din` and `hold_full <= 1`.
  - `din_ready = !hold_full && !rst`.
- Load: in IDLE with `hold_full`, on the next edge:
  - `shreg <= hold`, `hold_full <= 0`, FSM goes to START.
  - Accept and load never coincide.
- FSM states: IDLE, START, DATA, FINISH, GAP.
  - IDLE: all outputs 0. Goes to START when `hold_full`.
  - START: `start=1`, `ser=0`. Goes to DATA, with `bitcnt <= WIDTH-1`.
  - DATA: `ser = shreg[WIDTH-1]`. Each cycle `shreg <<= 1` and `bitcnt` decrements. At `bitcnt==0` goes to FINISH. Exactly WIDTH cycles.
  - FINISH: `finish=1`, `ser=0`. Goes to GAP with `gapcnt <= GAP-1` if GAP>0, else directly to IDLE.
  - GAP: all outputs 0. Goes to IDLE when `gapcnt==0`, otherwise decrements.
- `start`, `ser` and `finish` are registered, mutually exclusive as pulses, and glitch-free.
- `bitcnt` is `$clog2(WIDTH)` bits wide; `gapcnt` is 4 bits wide. Neither counter wraps in normal operation.
- Reset (asynchronous, any state, including mid-frame):
  - FSM to IDLE, `hold_full=0`, `shreg=0`, counters 0.
  - `start=0`, `ser=0`, `finish=0`, `busy=0`, `din_ready=0`.
  - A partially sent frame is abandoned, with no `finish` pulse.
  - After release, `din_ready=1` on the first cycle.
- `din` changes while not accepted are ignored. The holding register is never overwritten while full.

## Timing
- Accept edge = edge n.
  - `start` high during cycle n+1..n+2, i.e. set by edge n+1, cleared by edge n+2.
  - Data bit k (MSB = k0) is valid after edge n+2+k.
  - `finish` is valid after edge n+2+WIDTH.
  - The next load is possible at edge n+3+WIDTH+GAP.
- Frame period with the holding register always refilled: WIDTH+2+GAP cycles (11 for the defaults).
- Latency from accept to `start`: 1 cycle.
- Throughput: the next word may be accepted one cycle after each load edge, since `din_ready` rises then.
- `busy` falls on the edge where the FSM enters IDLE with `hold_full=0`.
- Outputs change only after `clk` rising edges, except on asynchronous reset.
- The downstream unit samples them on the following rising edge.

## Test plan
1. Single word, defaults: `din=8'hE7` (231), valid for 1 cycle.
   - Expect `start` for 1 cycle, then `ser` = 1,1,1,0,0,1,1,1, then `finish` for 1 cycle with `ser=0`, then 1 idle cycle.
   - Downstream mod3 reports remainder 0.
2. Back-to-back: `din_valid` held high, `din=8'hA5` then `8'h3C`.
   - Second word accepted during the first frame.
   - Second `start` exactly 11 cycles after the first.
   - `din_ready` low from the second accept until the second load.
   - `busy` stays high throughout.
3. Backpressure: present 3 words with valid held while the holding register is full.
   - No word lost or duplicated.
   - Serial output matches order 8'h01, 8'h80, 8'hFF.
4. Reset mid-frame: assert `rst` asynchronously after the 4th data bit of 8'h5A.
   - All outputs 0 immediately, no `finish` pulse.
   - After release, `din_ready=1`.
   - The next word 8'h0F produces a clean full frame.
5. WIDTH=4, GAP=0: words 4'h9, 4'h6.
   - Period 6 cycles; `start` follows `finish` directly.
   - `ser` = 1,0,0,1 then 0,1,1,0.
6. Boundary data 8'h00 and 8'hFF.
   - `ser` constant through the data phase.
   - `start` and `finish` positions unchanged; `ser=0` in the START and FINISH cycles.
